// File: rtl/camera_ctrl_fsm_if.sv
// Camera sequencer bundle: start request and exposure length in,
// pixel-array and readout strobes out.
interface camera_ctrl_fsm_if;
    logic       init;
    logic [4:0] ex_init;
    logic       erase;
    logic       expose;
    logic       nre_1;
    logic       nre_2;
    logic       adc;
    logic       busy;
    logic       done;

    modport master (
        output init, ex_init,
        input  erase, expose, nre_1, nre_2, adc, busy, done
    );

    modport slave (
        input  init, ex_init,
        output erase, expose, nre_1, nre_2, adc, busy, done
    );
endinterface

// File: rtl/camera_ctrl_fsm.sv
// Frame sequencer: erase while idle, expose for a clamped cycle count,
// then an 8-phase two-row readout with ADC strobes.
module camera_ctrl_fsm #(
    parameter logic [4:0] EX_MIN = 5'd2,
    parameter logic [4:0] EX_MAX = 5'd30
) (
    input logic              clk,
    input logic              reset,
    camera_ctrl_fsm_if.slave cam
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXPOSE  = 2'd1,
        READOUT = 2'd2
    } state_t;

    // Initialisers make the power-up state match the reset state.
    state_t     state  = IDLE;
    state_t     state_nxt;
    logic [4:0] ex_cnt = 5'd0;
    logic [2:0] ph_cnt = 3'd0;
    logic [4:0] ex_load;

    always_comb begin
        ex_load = cam.ex_init;
        if (cam.ex_init < EX_MIN)
            ex_load = EX_MIN;
        else if (cam.ex_init > EX_MAX)
            ex_load = EX_MAX;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ex_cnt <= 5'd0;
            ph_cnt <= 3'd0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    ph_cnt <= 3'd0;
                    if (cam.init)
                        ex_cnt <= ex_load;
                end
                EXPOSE: begin
                    ph_cnt <= 3'd0;
                    if (ex_cnt != 5'd0)
                        ex_cnt <= ex_cnt - 5'd1;
                end
                READOUT: ph_cnt <= ph_cnt + 3'd1;
                default: begin
                    ex_cnt <= 5'd0;
                    ph_cnt <= 3'd0;
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cam.init) state_nxt = EXPOSE;
            EXPOSE:  if (ex_cnt <= 5'd1) state_nxt = READOUT;
            READOUT: if (ph_cnt == 3'd7) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cam.erase  = 1'b1;
        cam.expose = 1'b0;
        cam.nre_1  = 1'b1;
        cam.nre_2  = 1'b1;
        cam.adc    = 1'b0;
        cam.busy   = 1'b0;
        cam.done   = 1'b0;
        unique case (state)
            IDLE: ;
            EXPOSE: begin
                cam.erase  = 1'b0;
                cam.expose = 1'b1;
                cam.busy   = 1'b1;
            end
            READOUT: begin
                cam.erase = 1'b0;
                cam.busy  = 1'b1;
                // Row 1 in phases 0-2, row 2 in 4-6; 3 and 7 are guard gaps.
                cam.nre_1 = (ph_cnt > 3'd2);
                cam.nre_2 = !(ph_cnt >= 3'd4 && ph_cnt <= 3'd6);
                cam.adc   = (ph_cnt[1:0] == 2'd1);
                cam.done  = (ph_cnt == 3'd7);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_camera_ctrl_fsm.sv
// Directed bench for camera_ctrl_fsm: frame-length table plus
// reset, re-trigger and back-to-back frame sequences.
module tb_camera_ctrl_fsm;

    logic clk = 1'b0;
    logic reset;

    camera_ctrl_fsm_if cam();

    camera_ctrl_fsm #(
        .EX_MIN(5'd2),
        .EX_MAX(5'd30)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .cam  (cam)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] IDLE_O = 7'b1011000;
    localparam logic [6:0] EXP_O  = 7'b0111010;

    typedef struct {
        logic [4:0] ex;
        int         n;
    } vec_t;

    vec_t vecs[7];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    function automatic logic [6:0] outs();
        return {cam.erase, cam.expose, cam.nre_1, cam.nre_2,
                cam.adc, cam.busy, cam.done};
    endfunction

    function automatic logic [6:0] ro(input int p);
        logic n1, n2, a, d;
        n1 = (p > 2);
        n2 = !(p >= 4 && p <= 6);
        a  = (p == 1 || p == 5);
        d  = (p == 7);
        return {1'b0, 1'b0, n1, n2, a, 1'b1, d};
    endfunction

    task automatic check(input string name, input logic [6:0] act,
                         input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Invariants on every cycle, independent of the sequence running.
    always @(negedge clk) begin
        if (cam.done === 1'b1)
            n_done++;
        n_checks++;
        if (cam.nre_1 === 1'b0 && cam.nre_2 === 1'b0) begin
            n_fail++;
            $display("FAIL inv_nre_overlap: got both low required not both low");
        end
        n_checks++;
        if (cam.adc === 1'b1 && (cam.nre_1 ^ cam.nre_2) !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_adc: got adc=1 nre=%b%b required one nre low",
                     cam.nre_1, cam.nre_2);
        end
        n_checks++;
        if (cam.busy !== ~cam.erase) begin
            n_fail++;
            $display("FAIL inv_busy: got busy=%b erase=%b required busy=!erase",
                     cam.busy, cam.erase);
        end
    end

    // Drive a start request; returns at the negedge of expose cycle 1.
    task automatic start(input logic [4:0] ex, input bit keep);
        @(negedge clk);
        cam.ex_init = ex;
        cam.init    = 1'b1;
        @(negedge clk);
        if (!keep)
            cam.init = 1'b0;
    endtask

    // Check n expose cycles then 8 readout phases; ends at phase 7.
    task automatic frame(input int n, input int chg_ex, input int pulse_ph);
        for (int i = 1; i <= n; i++) begin
            if (i > 1)
                @(negedge clk);
            check($sformatf("n=%0d expose cyc %0d", n, i), outs(), EXP_O);
            if (i == 3 && chg_ex >= 0)
                cam.ex_init = chg_ex[4:0];
        end
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            check($sformatf("n=%0d readout ph %0d", n, p), outs(), ro(p));
            if (pulse_ph >= 0)
                cam.init = (p == pulse_ph);
        end
    endtask

    initial begin
        int d0;
        vecs[0] = '{ex: 5'd16, n: 16};
        vecs[1] = '{ex: 5'd0,  n: 2};
        vecs[2] = '{ex: 5'd31, n: 30};
        vecs[3] = '{ex: 5'd1,  n: 2};
        vecs[4] = '{ex: 5'd2,  n: 2};
        vecs[5] = '{ex: 5'd30, n: 30};
        vecs[6] = '{ex: 5'd7,  n: 7};

        reset       = 1'b1;
        cam.init    = 1'b0;
        cam.ex_init = 5'd0;
        #1;
        check("power-up state", outs(), IDLE_O);
        @(negedge clk);
        @(negedge clk);
        check("reset state", outs(), IDLE_O);
        cam.init = 1'b1;
        @(negedge clk);
        check("reset overrides init", outs(), IDLE_O);
        cam.init = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check("idle hold", outs(), IDLE_O);

        d0 = n_done;
        foreach (vecs[k]) begin
            start(vecs[k].ex, 1'b0);
            frame(vecs[k].n, -1, -1);
            @(negedge clk);
            check($sformatf("idle after ex=%0d", vecs[k].ex), outs(), IDLE_O);
        end
        check_int("table done count", n_done - d0, 7);

        // ex_init change and init re-pulse mid-frame are ignored.
        d0 = n_done;
        start(5'd16, 1'b0);
        frame(16, 5, 2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("no requeue idle %0d", i), outs(), IDLE_O);
        end
        check_int("retrigger done count", n_done - d0, 1);

        // init held high: back-to-back frames with one idle gap.
        d0 = n_done;
        start(5'd4, 1'b1);
        for (int f = 0; f < 3; f++) begin
            frame(4, -1, -1);
            if (f == 2)
                cam.init = 1'b0;
            @(negedge clk);
            check($sformatf("gap idle %0d", f), outs(), IDLE_O);
            if (f < 2)
                @(negedge clk);
        end
        @(negedge clk);
        check("idle after held frames", outs(), IDLE_O);
        check_int("held done count", n_done - d0, 3);

        // Reset at expose cycle 5.
        d0 = n_done;
        start(5'd16, 1'b0);
        repeat (4) @(negedge clk);
        check("expose cyc 5 pre-reset", outs(), EXP_O);
        reset = 1'b1;
        @(negedge clk);
        check("reset mid expose", outs(), IDLE_O);
        reset = 1'b0;
        @(negedge clk);
        check("idle after expose abort", outs(), IDLE_O);

        // Reset at readout phase 2.
        start(5'd2, 1'b0);
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            check($sformatf("pre-reset ph %0d", p), outs(), ro(p));
        end
        reset = 1'b1;
        @(negedge clk);
        check("reset mid readout", outs(), IDLE_O);
        reset = 1'b0;
        @(negedge clk);
        check("idle after readout abort", outs(), IDLE_O);
        check_int("abort done count", n_done - d0, 0);

        // Counters restart cleanly after an abort.
        start(5'd3, 1'b0);
        frame(3, -1, -1);
        @(negedge clk);
        check("idle after recovery", outs(), IDLE_O);
        check_int("recovery done count", n_done - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
